tlc_phase_seq: RTL and testbench
================================

// Module: tlc_phase_seq
// PURPOSE
//   Traffic-light phase sequencer; consumer of the 1 Hz strobe from the one-second
//   clock divider. Counts seconds per phase and drives red/yellow/green lamps for
//   the north-south (NS) and east-west (EW) approaches. It also provides pedestrian
//   green-shortening and a flashing-yellow maintenance mode. Sits between the tick
//   generator and the board LED/lamp drivers, all in the 100 MHz clk_in domain.
// PARAMETERS
//   GREEN_SEC   10  green duration, ticks (1..2**CNT_W-1)
//   YELLOW_SEC  3   yellow duration, ticks (1..2**CNT_W-1)
//   ALLRED_SEC  1   all-red clearance duration, ticks (1..2**CNT_W-1)
//   PED_MIN     2   remaining-green clamp on pedestrian request (1..GREEN_SEC)
//   CNT_W       8   width of seconds counter
// PORTS
//   clk_in    in   1      100 MHz system clock
//   rst_n     in   1      synchronous reset, active-low
//   tick_in   in   1      1-cycle strobe, once per second
//   ped_req   in   1      pedestrian button, level; sampled every cycle
//   flash_en  in   1      maintenance mode request, level
//   ns_light  out  3      NS lamps {R,Y,G}, one-hot or all-off
//   ew_light  out  3      EW lamps {R,Y,G}, one-hot or all-off
//   phase     out  3      state code (encoding below)
//   sec_left  out  CNT_W  ticks remaining in current phase
// BEHAVIOUR
//   - Only clock is clk_in; reset is synchronous and active-low on rst_n.
//   - All outputs are registered and update on the same edge as the state.
//   - Reset, sampled on any edge: phase=RED_B, ns_light=ew_light=3'b100,
//     sec_left=ALLRED_SEC, ped_pend=0, flash phase bit=0.
//   - States/codes: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, FLASH=6.
//   - Cycle order: RED_B->NS_G->NS_Y->RED_A->EW_G->EW_Y->RED_B.
//   - Lamps by state:
//       NS_G: NS=G, EW=R.   NS_Y: NS=Y, EW=R.
//       EW_G: NS=R, EW=G.   EW_Y: NS=R, EW=Y.
//       RED_A/RED_B: both R.
//   - Counting happens only on cycles with tick_in=1; other cycles hold the count.
//     - sec_left==1 on a tick: advance to the next state and load its duration.
//     - Otherwise: sec_left <= sec_left-1.
//     - Each phase therefore lasts exactly its duration in ticks.
//   - ped_pend is set on any cycle with ped_req=1. It is cleared on entry to NS_Y
//     or EW_Y and on reset.
//   - In NS_G/EW_G with ped_pend=1 on a tick (not the advancing tick):
//     sec_left <= min(sec_left-1, PED_MIN). The clamp never lengthens green.
//     No effect in other states.
//   - ped_req and tick_in in the same cycle: ped_pend is set and the clamp applies
//     on that same tick.
//   - flash_en=1 from any non-FLASH state: enter FLASH at the next edge, regardless
//     of tick. In FLASH:
//     - sec_left=0; ns_light=ew_light={0,f,0}; f starts at 1.
//     - f toggles on every tick.
//   - flash_en=0 in FLASH: go to RED_B with sec_left=ALLRED_SEC, both lamps R, f=0.
//   - flash_en takes priority over tick-driven advance in the same cycle.
//   - Invariant: never G or Y on both approaches simultaneously except FLASH Y/Y.
//     Never more than one lamp lit per approach.
//   - sec_left is never 0 outside FLASH. No wrap-around; the counter is loaded,
//     never underflowed.
//   - Mid-operation rst_n=0 abandons the phase immediately; reset values apply at
//     that edge.
// TESTING
//   1. Reset, then 40 ticks spaced 5 clks:
//      RED_B 1 tick, NS_G 10, NS_Y 3, RED_A 1, EW_G 10, EW_Y 3, then wrap to RED_B.
//   2. ped_req pulse in NS_G with sec_left=8:
//      next tick gives sec_left=2, NS_Y after 2 more ticks, ped_pend cleared.
//   3. ped_req in NS_G with sec_left=2:
//      next tick gives 1 (no lengthening); ped_req in RED_A has no effect until
//      EW_G.
//   4. flash_en=1 in EW_G with a simultaneous tick:
//      FLASH next edge, lamps Y/Y, then off/off and back to Y/Y on alternate
//      ticks; deassert gives RED_B with sec_left=1.
//   5. rst_n=0 for 1 clk mid NS_Y:
//      next edge phase=5, both R, sec_left=1; ticks with no tick_in hold all
//      outputs.
//   6. Assertion run, 10k random ticks/ped/flash: lamp invariants hold every cycle;
//      sec_left!=0 outside FLASH.

Source files
------------

// File: rtl/tlc_phase_seq.sv
// Traffic-light phase sequencer driven by a 1 Hz tick strobe.
// Pedestrian green-shortening and flashing-yellow maintenance mode.
module tlc_phase_seq #(
  parameter int GREEN_SEC  = 10,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 1,
  parameter int PED_MIN    = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             ped_req,
  input  logic             flash_en,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] sec_left
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_SEC);
  localparam logic [CNT_W-1:0] T_PEDMIN = CNT_W'(PED_MIN);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  state_t           nxt;
  logic             ped_pend;
  logic             flash_f;
  logic             is_green;
  logic [CNT_W-1:0] dec;

  function automatic state_t next_of(input state_t s);
    unique case (s)
      RED_B:   next_of = NS_G;
      NS_G:    next_of = NS_Y;
      NS_Y:    next_of = RED_A;
      RED_A:   next_of = EW_G;
      EW_G:    next_of = EW_Y;
      EW_Y:    next_of = RED_B;
      default: next_of = RED_B;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dur_of(input state_t s);
    unique case (s)
      NS_G, EW_G: dur_of = T_GREEN;
      NS_Y, EW_Y: dur_of = T_YELLOW;
      default:    dur_of = T_ALLRED;
    endcase
  endfunction

  function automatic logic [2:0] ns_of(input state_t s);
    unique case (s)
      NS_G:    ns_of = LAMP_G;
      NS_Y:    ns_of = LAMP_Y;
      default: ns_of = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input state_t s);
    unique case (s)
      EW_G:    ew_of = LAMP_G;
      EW_Y:    ew_of = LAMP_Y;
      default: ew_of = LAMP_R;
    endcase
  endfunction

  assign nxt      = next_of(state);
  assign dec      = sec_left - ONE;
  assign is_green = (state == NS_G) || (state == EW_G);
  assign phase    = state;

  // Phase FSM with registered lamps, countdown and pedestrian latch
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state    <= RED_B;
      sec_left <= T_ALLRED;
      ns_light <= LAMP_R;
      ew_light <= LAMP_R;
      ped_pend <= 1'b0;
      flash_f  <= 1'b0;
    end else begin
      ped_pend <= ped_pend | ped_req;
      if (state == FLASH) begin
        if (!flash_en) begin
          state    <= RED_B;
          sec_left <= T_ALLRED;
          ns_light <= LAMP_R;
          ew_light <= LAMP_R;
          flash_f  <= 1'b0;
        end else if (tick_in) begin
          flash_f  <= ~flash_f;
          ns_light <= {1'b0, ~flash_f, 1'b0};
          ew_light <= {1'b0, ~flash_f, 1'b0};
        end
      end else if (flash_en) begin
        state    <= FLASH;
        sec_left <= '0;
        flash_f  <= 1'b1;
        ns_light <= LAMP_Y;
        ew_light <= LAMP_Y;
      end else if (tick_in) begin
        if (sec_left == ONE) begin
          state    <= nxt;
          sec_left <= dur_of(nxt);
          ns_light <= ns_of(nxt);
          ew_light <= ew_of(nxt);
          if ((nxt == NS_Y) || (nxt == EW_Y))
            ped_pend <= 1'b0;
        end else if (is_green && (ped_pend || ped_req)
                     && (dec > T_PEDMIN)) begin
          sec_left <= T_PEDMIN;
        end else begin
          sec_left <= dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlc_phase_seq.sv
// Directed and randomized checks for the traffic-light sequencer.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_tlc_phase_seq;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [7:0] sec_left;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  tlc_phase_seq dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .phase    (phase),
    .sec_left (sec_left)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic st(input string tag, input int p, input int s,
                    input logic [2:0] ns, input logic [2:0] ew);
    chk({tag, "_phase"}, 32'(phase), 32'(p));
    chk({tag, "_sec"}, 32'(sec_left), 32'(s));
    chk({tag, "_ns"}, 32'(ns_light), 32'(ns));
    chk({tag, "_ew"}, 32'(ew_light), 32'(ew));
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      tick_in = 1'b1;
      @(negedge clk_in);
      tick_in = 1'b0;
      repeat (3) @(negedge clk_in);
    end
  endtask

  task automatic ped_pulse();
    @(negedge clk_in);
    ped_req = 1'b1;
    @(negedge clk_in);
    ped_req = 1'b0;
  endtask

  // Expected sequence for test 1: phase, seconds and lamps after each tick
  int       e_ph[40];
  int       e_sc[40];
  logic [2:0] e_ns[40];
  logic [2:0] e_ew[40];

  initial begin
    int k;
    k = 0;
    // NS_G 10 ticks
    for (int s = 10; s >= 1; s--) begin
      e_ph[k] = 0; e_sc[k] = s; e_ns[k] = G; e_ew[k] = R; k++;
    end
    for (int s = 3; s >= 1; s--) begin
      e_ph[k] = 1; e_sc[k] = s; e_ns[k] = Y; e_ew[k] = R; k++;
    end
    e_ph[k] = 2; e_sc[k] = 1; e_ns[k] = R; e_ew[k] = R; k++;
    for (int s = 10; s >= 1; s--) begin
      e_ph[k] = 3; e_sc[k] = s; e_ns[k] = R; e_ew[k] = G; k++;
    end
    for (int s = 3; s >= 1; s--) begin
      e_ph[k] = 4; e_sc[k] = s; e_ns[k] = R; e_ew[k] = Y; k++;
    end
    e_ph[k] = 5; e_sc[k] = 1; e_ns[k] = R; e_ew[k] = R; k++;
    for (int s = 10; s >= 1; s--) begin
      e_ph[k] = 0; e_sc[k] = s; e_ns[k] = G; e_ew[k] = R; k++;
    end
    e_ph[k] = 1; e_sc[k] = 3; e_ns[k] = Y; e_ew[k] = R; k++;
    e_ph[k] = 1; e_sc[k] = 2; e_ns[k] = Y; e_ew[k] = R; k++;

    // 1. reset state and a full cycle plus wrap
    do_reset();
    st("rst", 5, 1, R, R);
    for (int i = 0; i < 40; i++) begin
      ticks(1);
      st($sformatf("t1_%0d", i), e_ph[i], e_sc[i], e_ns[i], e_ew[i]);
    end

    // 2. pedestrian request with sec_left=8 clamps to 2
    do_reset();
    ticks(3);
    st("t2_pre", 0, 8, G, R);
    ped_pulse();
    st("t2_hold", 0, 8, G, R);
    ticks(1);
    st("t2_clamp", 0, 2, G, R);
    ticks(1);
    st("t2_one", 0, 1, G, R);
    ticks(1);
    st("t2_nsy", 1, 3, Y, R);
    ticks(4);
    st("t2_ewg", 3, 10, R, G);
    ticks(1);
    st("t2_cleared", 3, 9, R, G);

    // 3. no lengthening; request in RED_A acts in EW_G
    do_reset();
    ticks(9);
    st("t3_pre", 0, 2, G, R);
    ped_pulse();
    ticks(1);
    st("t3_nolong", 0, 1, G, R);
    ticks(1);
    st("t3_nsy", 1, 3, Y, R);
    ticks(3);
    st("t3_reda", 2, 1, R, R);
    ped_pulse();
    st("t3_reda_ped", 2, 1, R, R);
    ticks(1);
    st("t3_ewg", 3, 10, R, G);
    ticks(1);
    st("t3_ewclamp", 3, 2, R, G);
    ticks(2);
    st("t3_ewy", 4, 3, R, Y);

    // 4. flash entry with coincident tick, toggling, exit
    do_reset();
    ticks(15);
    st("t4_pre", 3, 10, R, G);
    @(negedge clk_in);
    flash_en = 1'b1;
    tick_in = 1'b1;
    @(negedge clk_in);
    tick_in = 1'b0;
    st("t4_flash", 6, 0, Y, Y);
    repeat (4) @(negedge clk_in);
    st("t4_flash_hold", 6, 0, Y, Y);
    ticks(1);
    st("t4_off", 6, 0, OFF, OFF);
    ticks(1);
    st("t4_on", 6, 0, Y, Y);
    @(negedge clk_in);
    flash_en = 1'b0;
    @(negedge clk_in);
    st("t4_exit", 5, 1, R, R);
    ticks(1);
    st("t4_nsg", 0, 10, G, R);

    // 5. reset mid NS_Y, then idle cycles hold
    ticks(10);
    st("t5_nsy", 1, 3, Y, R);
    ticks(1);
    st("t5_nsy2", 1, 2, Y, R);
    do_reset();
    st("t5_rst", 5, 1, R, R);
    repeat (5) @(negedge clk_in);
    st("t5_hold", 5, 1, R, R);

    // 6. random stimulus, invariants every cycle
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk_in);
      tick_in = ($urandom_range(0, 3) == 0);
      ped_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) flash_en = ~flash_en;
      @(posedge clk_in);
      #1;
      chk("inv_ns_onehot", 32'($countones(ns_light) <= 1), 32'd1);
      chk("inv_ew_onehot", 32'($countones(ew_light) <= 1), 32'd1);
      chk("inv_conflict",
          32'(!((ns_light[1:0] != 2'b00) && (ew_light[1:0] != 2'b00)) ||
              (phase == 3'd6 && ns_light == Y && ew_light == Y)), 32'd1);
      chk("inv_sec", 32'((phase == 3'd6) || (sec_left != 8'd0)), 32'd1);
      chk("inv_phase", 32'(phase <= 3'd6), 32'd1);
    end
    tick_in = 1'b0;
    ped_req = 1'b0;
    flash_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
